accident_alarm_ctrl: RTL and testbench

//  Sequencing controller for the combinational accident-alarm decoder (4 sensor bits -> alarm bit).
//  - Debounces the decoder output and latches an alarm event.
//  - Drives a pulsed siren and a steady lamp.
//  - Escalates to an emergency-call request if no operator acknowledge arrives in time.
//  - Enforces a hold-off after acknowledge before the block can re-arm.

---
 rtl/accident_alarm_pkg.sv | 25 ++
 rtl/accident_alarm_ctrl_debounce.sv | 34 +++
 rtl/accident_alarm_ctrl.sv | 156 +++++++++++++++
 tb/tb_accident_alarm_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/accident_alarm_pkg.sv
// Shared definitions for the accident alarm controller:
// state encoding and default timing constants.
package accident_alarm_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CONFIRM  = 3'd1;
    localparam logic [2:0] ST_ALARM    = 3'd2;
    localparam logic [2:0] ST_ESCALATE = 3'd3;
    localparam logic [2:0] ST_HOLDOFF  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_CONFIRM  = ST_CONFIRM,
        S_ALARM    = ST_ALARM,
        S_ESCALATE = ST_ESCALATE,
        S_HOLDOFF  = ST_HOLDOFF
    } state_t;

    localparam int DEF_DEBOUNCE    = 4;
    localparam int DEF_BLINK_HALF  = 8;
    localparam int DEF_ESC_TIMEOUT = 64;
    localparam int DEF_HOLDOFF     = 16;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/accident_alarm_ctrl_debounce.sv
// Consecutive-sample debouncer for the decoder output;
// emits a one-cycle latch pulse on the DEBOUNCE-th high sample.
module alarm_debounce
    import accident_alarm_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic alarm_in,
    output logic latch
);

    localparam int DEB_W = $clog2(DEBOUNCE + 1);

    logic [DEB_W-1:0] deb;

    // The latch fires on the edge that takes the final high sample.
    assign latch = en && alarm_in && (deb == DEB_W'(DEBOUNCE - 1));

    // Count consecutive high samples; any low sample or leaving the
    // arming states restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
        end else if (!en || !alarm_in || latch) begin
            deb <= '0;
        end else begin
            deb <= deb + 1'b1;
        end
    end

endmodule

// File: rtl/accident_alarm_ctrl.sv
// Accident alarm sequencer: debounced latch, pulsed siren, lamp,
// escalation to an emergency call, and post-ack hold-off.
module accident_alarm_ctrl
    import accident_alarm_pkg::*;
#(
    parameter int DEBOUNCE    = DEF_DEBOUNCE,
    parameter int BLINK_HALF  = DEF_BLINK_HALF,
    parameter int ESC_TIMEOUT = DEF_ESC_TIMEOUT,
    parameter int HOLDOFF     = DEF_HOLDOFF,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       sensor,
    input  logic             alarm_in,
    input  logic             ack,
    output logic             siren,
    output logic             lamp,
    output logic             call_req,
    output logic [3:0]       sensor_snap,
    output logic [CNT_W-1:0] event_cnt,
    output logic [2:0]       state
);

    localparam int TMR_MAX = (ESC_TIMEOUT > HOLDOFF) ? ESC_TIMEOUT : HOLDOFF;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_HALF + 1);

    state_t             state_q, state_d;
    logic               siren_q, siren_d;
    logic               lamp_q, lamp_d;
    logic               call_q, call_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [BLK_W-1:0]   blink_q, blink_d;
    logic [3:0]         snap_q, snap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               arming;
    logic               latch;

    assign arming = (state_q == S_IDLE) || (state_q == S_CONFIRM);

    alarm_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (arming),
        .alarm_in (alarm_in),
        .latch    (latch)
    );

    // Register all state and outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            siren_q <= 1'b0;
            lamp_q  <= 1'b0;
            call_q  <= 1'b0;
            tmr_q   <= '0;
            blink_q <= '0;
            snap_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            siren_q <= siren_d;
            lamp_q  <= lamp_d;
            call_q  <= call_d;
            tmr_q   <= tmr_d;
            blink_q <= blink_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-output logic; the shared timer measures
    // time in ALARM, then time in HOLDOFF.
    always_comb begin
        state_d = state_q;
        siren_d = siren_q;
        lamp_d  = lamp_q;
        call_d  = call_q;
        tmr_d   = tmr_q;
        blink_d = blink_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_CONFIRM: begin
                if (latch) begin
                    state_d = S_ALARM;
                    snap_d  = sensor;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    siren_d = 1'b1;
                    lamp_d  = 1'b1;
                    call_d  = 1'b0;
                    tmr_d   = '0;
                    blink_d = '0;
                end else if (alarm_in) begin
                    state_d = S_CONFIRM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ALARM: begin
                if (ack) begin
                    state_d = S_HOLDOFF;
                    siren_d = 1'b0;
                    lamp_d  = 1'b0;
                    call_d  = 1'b0;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(ESC_TIMEOUT - 1)) begin
                    state_d = S_ESCALATE;
                    siren_d = 1'b1;
                    call_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                    if (blink_q == BLK_W'(BLINK_HALF - 1)) begin
                        blink_d = '0;
                        siren_d = ~siren_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
            end
            S_ESCALATE: begin
                if (ack) begin
                    state_d = S_HOLDOFF;
                    siren_d = 1'b0;
                    lamp_d  = 1'b0;
                    call_d  = 1'b0;
                    tmr_d   = '0;
                end
            end
            S_HOLDOFF: begin
                if (tmr_q == TMR_W'(HOLDOFF - 1)) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign siren       = siren_q;
    assign lamp        = lamp_q;
    assign call_req    = call_q;
    assign sensor_snap = snap_q;
    assign event_cnt   = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_accident_alarm_ctrl.sv
// Directed bench for accident_alarm_ctrl: default instance plus a
// small instance with DEBOUNCE=1 and a 2-bit event counter.
module tb_accident_alarm_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] sensor;
    logic       alarm_in;
    logic       ack;
    logic       siren;
    logic       lamp;
    logic       call_req;
    logic [3:0] sensor_snap;
    logic [7:0] event_cnt;
    logic [2:0] state;

    logic [3:0] sensor2;
    logic       alarm2;
    logic       ack2;
    logic       siren2;
    logic       lamp2;
    logic       call2;
    logic [3:0] snap2;
    logic [1:0] cnt2;
    logic [2:0] state2;

    int checks;
    int errors;

    accident_alarm_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor      (sensor),
        .alarm_in    (alarm_in),
        .ack         (ack),
        .siren       (siren),
        .lamp        (lamp),
        .call_req    (call_req),
        .sensor_snap (sensor_snap),
        .event_cnt   (event_cnt),
        .state       (state)
    );

    accident_alarm_ctrl #(
        .DEBOUNCE    (1),
        .BLINK_HALF  (2),
        .ESC_TIMEOUT (8),
        .HOLDOFF     (2),
        .CNT_W       (2)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor      (sensor2),
        .alarm_in    (alarm2),
        .ack         (ack2),
        .siren       (siren2),
        .lamp        (lamp2),
        .call_req    (call2),
        .sensor_snap (snap2),
        .event_cnt   (cnt2),
        .state       (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_siren"}, 32'(siren), 32'd0);
        check({tag, "_lamp"}, 32'(lamp), 32'd0);
        check({tag, "_call"}, 32'(call_req), 32'd0);
    endtask

    initial begin
        bit seen;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        sensor   = 4'b0000;
        alarm_in = 1'b0;
        ack      = 1'b0;
        sensor2  = 4'b0000;
        alarm2   = 1'b0;
        ack2     = 1'b0;

        // Reset state
        #12;
        check("rst_state", 32'(state), 32'd0);
        check_quiet("rst");
        check("rst_cnt", 32'(event_cnt), 32'd0);
        check("rst_snap", 32'(sensor_snap), 32'd0);
        #10 rst_n = 1'b1;
        step();
        check("idle_state", 32'(state), 32'd0);

        // 1: three high samples then low never latch
        alarm_in = 1'b1;
        step();
        check("t1_confirm1", 32'(state), 32'd1);
        steps(2);
        check("t1_confirm3", 32'(state), 32'd1);
        alarm_in = 1'b0;
        step();
        check("t1_back_idle", 32'(state), 32'd0);
        check("t1_lamp", 32'(lamp), 32'd0);
        check("t1_cnt", 32'(event_cnt), 32'd0);

        // ack in IDLE is ignored
        ack = 1'b1;
        step();
        check("ack_idle", 32'(state), 32'd0);
        ack = 1'b0;

        // 2: latch at the 4th edge with snapshot
        sensor   = 4'b1011;
        alarm_in = 1'b1;
        steps(3);
        check("t2_pre_latch", 32'(state), 32'd1);
        check("t2_pre_lamp", 32'(lamp), 32'd0);
        step();
        check("t2_alarm", 32'(state), 32'd2);
        check("t2_snap", 32'(sensor_snap), 32'hb);
        check("t2_cnt", 32'(event_cnt), 32'd1);
        check("t2_siren_l0", 32'(siren), 32'd1);
        check("t2_lamp", 32'(lamp), 32'd1);
        sensor = 4'b0110;
        steps(7);
        check("t2_siren_l7", 32'(siren), 32'd1);
        step();
        check("t2_siren_l8", 32'(siren), 32'd0);
        check("t2_lamp_l8", 32'(lamp), 32'd1);
        steps(7);
        check("t2_siren_l15", 32'(siren), 32'd0);
        step();
        check("t2_siren_l16", 32'(siren), 32'd1);
        check("t2_snap_hold", 32'(sensor_snap), 32'hb);

        // 3: escalation 64 cycles after latch, ack, hold-off, re-latch
        steps(47);
        check("t3_l63_state", 32'(state), 32'd2);
        check("t3_l63_call", 32'(call_req), 32'd0);
        step();
        check("t3_esc_state", 32'(state), 32'd3);
        check("t3_esc_call", 32'(call_req), 32'd1);
        check("t3_esc_siren", 32'(siren), 32'd1);
        steps(9);
        check("t3_esc_steady", 32'(siren), 32'd1);
        check("t3_esc_stay", 32'(state), 32'd3);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t3_holdoff", 32'(state), 32'd4);
        check_quiet("t3_ho");
        steps(15);
        check("t3_ho15", 32'(state), 32'd4);
        step();
        check("t3_ho_idle", 32'(state), 32'd0);
        steps(3);
        check("t3_reconfirm", 32'(state), 32'd1);
        step();
        check("t3_relatch", 32'(state), 32'd2);
        check("t3_cnt2", 32'(event_cnt), 32'd2);
        check("t3_snap2", 32'(sensor_snap), 32'h6);

        // 4: ack on the escalation-timeout edge wins
        steps(63);
        check("t4_l63_call", 32'(call_req), 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t4_holdoff", 32'(state), 32'd4);
        check_quiet("t4");
        alarm_in = 1'b0;
        steps(16);
        check("t4_idle", 32'(state), 32'd0);

        // 5: asynchronous reset during ESCALATE
        alarm_in = 1'b1;
        steps(4);
        check("t5_alarm", 32'(state), 32'd2);
        check("t5_cnt3", 32'(event_cnt), 32'd3);
        steps(64);
        check("t5_esc", 32'(state), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_state", 32'(state), 32'd0);
        check_quiet("t5_rst");
        check("t5_rst_cnt", 32'(event_cnt), 32'd0);
        alarm_in = 1'b0;
        #10 rst_n = 1'b1;
        step();
        check("t5_rel_state", 32'(state), 32'd0);
        check("t5_rel_cnt", 32'(event_cnt), 32'd0);

        // 6: DEBOUNCE=1 direct latch, 2-bit counter saturates
        sensor2 = 4'b0101;
        alarm2  = 1'b1;
        step();
        check("t6_direct", 32'(state2), 32'd2);
        check("t6_snap", 32'(snap2), 32'h5);
        for (int i = 0; i < 5; i++) begin
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                if (state2 == 3'd2) seen = 1'b1;
                else step();
            end
            check("t6_latched", 32'(seen), 32'd1);
            check("t6_cnt", 32'(cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
            ack2 = 1'b1;
            step();
            ack2 = 1'b0;
            check("t6_holdoff", 32'(state2), 32'd4);
        end
        check("t6_cnt_sat", 32'(cnt2), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
